sqrt_seq_ctrl: RTL
==================

// Module: sqrt_seq_ctrl
// PURPOSE
//  Sequencer for the shared 8-bit add/sub/max arithmetic unit (AU). It computes
//  floor(sqrt(X)) and remainder X-root^2 for an unsigned 8-bit radicand by
//  odd-number subtraction. All adds and subtracts are issued to the external AU.
//  Sits between the sqrt front-end (valid/ready in) and the result consumer
//  (valid/ready out). Owns the AU's A/B/sel inputs while busy.
// PARAMETERS
//  DATA_W   8  radicand/AU width; only 8 is supported
//  AU_LAT   1  AU latency in cycles: operands registered at the issue edge
//              -> au_out valid AU_LAT cycles later
// PORTS
//  clk        in   1  rising-edge clock
//  rst_n      in   1  asynchronous, active-low reset
//  in_valid   in   1  radicand offered
//  in_ready   out  1  high only in IDLE
//  in_x       in   8  unsigned radicand, sampled on in_valid&in_ready
//  out_valid  out  1  result held valid until accepted
//  out_ready  in   1  consumer accepts result
//  out_root   out  4  floor(sqrt(in_x))
//  out_rem    out  8  in_x - out_root^2
//  busy       out  1  high in every state except IDLE
//  au_a       out  8  AU operand A
//  au_b       out  8  AU operand B
//  au_sel     out  2  AU op: 00=add, 10=sub(A-B), 11=max; 01 is never driven
//  au_out     in   8  AU result
// BEHAVIOUR
//  Reset (async, any state): state=IDLE, rem/odd/root=0, out_valid=0,
//   in_ready=1, busy=0, au_a=au_b=0, au_sel=00. Outputs change on clk only
//   after rst_n deasserts.
//  Internal regs: rem[7:0], odd[7:0], root[3:0], wait counter [clog2(AU_LAT+1)].
//  FSM:
//   IDLE    : in_ready=1. On accept: rem<=in_x, odd<=1, root<=0 -> CHECK.
//   CHECK   : Local unsigned compare rem>=odd (not done by the AU).
//             True -> SUB_ISS; false -> DONE.
//   SUB_ISS : 1 cycle. au_a=rem, au_b=odd, au_sel=10 -> SUB_WT.
//   SUB_WT  : AU_LAT cycles. On the last edge, rem<=au_out -> ADD_ISS.
//   ADD_ISS : 1 cycle. au_a=odd, au_b=8'd2, au_sel=00 -> ADD_WT.
//   ADD_WT  : AU_LAT cycles. On the last edge, odd<=au_out, root<=root+1
//             -> CHECK.
//   DONE    : out_valid=1. out_root=root and out_rem=rem, held stable.
//             If out_ready -> IDLE (out_valid drops on the same edge).
//  au_a/au_b=0 and au_sel=00 in every non-ISS state. The AU output is ignored
//   outside the capture edges.
//  Latency from accept edge to the out_valid rise edge:
//   root*(3+2*AU_LAT)+1 cycles (AU_LAT=1: 5*root+1).
//  Width rules: odd is at most 31 (root at most 15), so no 8-bit wrap.
//   rem>=odd is checked before each sub, so rem never goes negative.
//   root saturation is never reached.
//  in_valid while busy: ignored (in_ready=0) and in_x is not sampled.
//  DONE with out_ready and in_valid both high: the new radicand is not accepted
//   that cycle; it is accepted in the following IDLE cycle (1 bubble).
//  Reset asserted mid-iteration: the partial result is discarded and no
//   out_valid is produced. The AU's own pipeline contents are don't-care.
// TESTING
//  Reset value check: assert rst_n=0 mid-run -> all outputs equal the reset
//   values immediately; IDLE after release.
//  X=0 -> root=0, rem=0, out_valid 1 cycle after accept; au_sel never leaves 00.
//  X=16 -> root=4, rem=0, latency 21; au_sel sequence 10,00 repeated 4 times.
//  X=255 -> root=15, rem=30, latency 76. Also X=1 -> root=1, rem=0, latency 6.
//  Hold out_ready=0 for 10 cycles in DONE -> outputs stable and in_ready=0;
//   then out_ready=1 with in_valid=1, X=9 -> accepted next cycle, root=3, rem=0.
//  Sweep X=0..255 against a reference model, with AU_LAT=1 and AU_LAT=2
//   (AU model delayed accordingly) -> all roots/remainders match and the
//   latency formula holds.

Source files
------------

// File: rtl/sqrt_seq_ctrl.sv
// rtl/sqrt_seq_ctrl.sv - integer square root sequencer driving a shared add/sub/max AU
// Odd-number subtraction: root counts how many successive odd numbers fit into the radicand.
module sqrt_seq_ctrl #(
    parameter int DATA_W = 8,
    parameter int AU_LAT = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [DATA_W-1:0]   in_x,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [DATA_W/2-1:0] out_root,
    output logic [DATA_W-1:0]   out_rem,
    output logic                busy,
    output logic [DATA_W-1:0]   au_a,
    output logic [DATA_W-1:0]   au_b,
    output logic [1:0]          au_sel,
    input  logic [DATA_W-1:0]   au_out
);

    localparam int CNT_W = (AU_LAT > 1) ? $clog2(AU_LAT + 1) : 1;
    localparam logic [CNT_W-1:0] WAIT_INIT = CNT_W'(AU_LAT - 1);

    localparam logic [1:0] SEL_ADD = 2'b00;
    localparam logic [1:0] SEL_SUB = 2'b10;

    typedef enum logic [2:0] {
        IDLE,
        CHECK,
        SUB_ISS,
        SUB_WT,
        ADD_ISS,
        ADD_WT,
        DONE
    } state_t;

    state_t               state;
    logic [DATA_W-1:0]    rem;
    logic [DATA_W-1:0]    odd;
    logic [DATA_W/2-1:0]  root;
    logic [CNT_W-1:0]     wait_cnt;

    assign out_root = root;
    assign out_rem  = rem;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            rem       <= '0;
            odd       <= '0;
            root      <= '0;
            wait_cnt  <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            au_a      <= '0;
            au_b      <= '0;
            au_sel    <= SEL_ADD;
        end else begin
            // AU operands are only non-zero during the single issue cycle
            au_a   <= '0;
            au_b   <= '0;
            au_sel <= SEL_ADD;
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        rem      <= in_x;
                        odd      <= DATA_W'(1);
                        root     <= '0;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                        state    <= CHECK;
                    end
                end
                CHECK: begin
                    if (rem >= odd) begin
                        au_a   <= rem;
                        au_b   <= odd;
                        au_sel <= SEL_SUB;
                        state  <= SUB_ISS;
                    end else begin
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                SUB_ISS: begin
                    wait_cnt <= WAIT_INIT;
                    state    <= SUB_WT;
                end
                SUB_WT: begin
                    if (wait_cnt == '0) begin
                        rem    <= au_out;
                        au_a   <= odd;
                        au_b   <= DATA_W'(2);
                        au_sel <= SEL_ADD;
                        state  <= ADD_ISS;
                    end else begin
                        wait_cnt <= wait_cnt - 1'b1;
                    end
                end
                ADD_ISS: begin
                    wait_cnt <= WAIT_INIT;
                    state    <= ADD_WT;
                end
                ADD_WT: begin
                    if (wait_cnt == '0) begin
                        odd   <= au_out;
                        root  <= root + 1'b1;
                        state <= CHECK;
                    end else begin
                        wait_cnt <= wait_cnt - 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
